// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the sprite ROM arbiter
package sprite_pkg;

   localparam int SPRITE_ADDR_W = 19;
   localparam int SPRITE_DATA_W = 24;

   // Pixel value the renderers treat as "draw nothing".
   localparam logic [23:0] TRANSPARENT = 24'hFFFFFF;

   // Wide enough for the largest supported requester count (8).
   localparam int REQ_ID_MAX_W = 3;
   typedef logic [REQ_ID_MAX_W-1:0] req_id_t;

   // Travels alongside the ROM read so the response knows who asked and whether it was legal.
   typedef struct packed {
      logic    valid;
      req_id_t id;
      logic    err;
   } rsp_tag_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick: first request at or after rr_ptr
module rr_priority_picker #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] rr_ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] winner,
   output logic          any_req
);

   logic [IW-1:0] idx;

   // Scan rr_ptr, rr_ptr+1, ... wrapping at N; the first asserted request wins.
   always_comb begin
      grant   = '0;
      winner  = '0;
      any_req = 1'b0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(rr_ptr) + k) % N);
         if (!any_req && req[idx]) begin
            any_req    = 1'b1;
            winner     = idx;
            grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sharing of one sprite ROM with tagged responses
module sprite_rom_arbiter
   import sprite_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int ADDR_W    = SPRITE_ADDR_W,
   parameter int DATA_W    = SPRITE_DATA_W,
   parameter int ROM_DEPTH = 1024,
   parameter int ROM_LAT   = 1,
   localparam int ID_W     = $clog2(N_REQ)
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic                    frame_start,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        grant,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_data,
   output logic                    rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    rsp_err
);

   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   ptr_next;
   logic [N_REQ-1:0]  pick;
   logic              any_req;
   logic              accept;
   logic              win_err;
   logic [ADDR_W-1:0] win_addr;
   rsp_tag_t [ROM_LAT:0] tag_q;
   logic              unused_tag_id;

   rr_priority_picker #(.N(N_REQ), .IW(ID_W)) u_picker (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .grant   (pick),
      .winner  (winner),
      .any_req (any_req)
   );

   // Nothing is granted while reset is held, so no requester believes it was served.
   assign grant  = Reset_n ? pick : '0;
   assign accept = any_req & Reset_n;

   // The id field is sized for the largest arbiter; upper bits are don't-care here.
   assign unused_tag_id = ^tag_q[ROM_LAT].id;

   // Select the winning requester's address slice.
   always_comb begin
      win_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (winner == ID_W'(i)) begin
            win_addr = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign win_err  = (33'(win_addr) >= 33'(ROM_DEPTH));
   assign ptr_next = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);

   // Round-robin pointer: start after the last winner; vsync realigns to requester 0.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rr_ptr <= '0;
      end else if (frame_start) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= ptr_next;
      end
   end

   // ROM address register and tag pipeline; illegal addresses are parked at word 0.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rom_addr <= '0;
         tag_q    <= '0;
      end else begin
         if (accept) begin
            rom_addr <= win_err ? '0 : win_addr;
         end
         tag_q[0] <= accept ? {1'b1, req_id_t'(winner), win_err} : '0;
         for (int s = 1; s <= ROM_LAT; s++) begin
            tag_q[s] <= tag_q[s-1];
         end
      end
   end

   // Registered response: tag meets ROM data; errors return a transparent pixel.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= tag_q[ROM_LAT].valid;
         if (tag_q[ROM_LAT].valid) begin
            rsp_id   <= tag_q[ROM_LAT].id[ID_W-1:0];
            rsp_err  <= tag_q[ROM_LAT].err;
            rsp_data <= tag_q[ROM_LAT].err ? DATA_W'(TRANSPARENT) : rom_data;
         end
      end
   end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - self-checking bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;

   localparam int N     = 4;
   localparam int AW    = 19;
   localparam int DW    = 24;
   localparam int DEPTH = 1024;

   logic            Clk = 1'b0;
   logic            Reset_n = 1'b0;
   logic            frame_start = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N-1:0]    grant;
   logic [AW-1:0]   rom_addr;
   logic [DW-1:0]   rom_data = '0;
   logic            rsp_valid;
   logic [1:0]      rsp_id;
   logic [DW-1:0]   rsp_data;
   logic            rsp_err;

   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   exp_t          exp_q[$];
   int            m_ptr = 0;
   int            cyc = 0;
   int            n_tests = 0;
   int            n_fail = 0;
   logic [N-1:0]  exp_grant;
   logic [N-1:0]  got_grant;
   logic          exp_v;
   logic          exp_err;
   int            exp_id;
   logic [DW-1:0] exp_data;

   sprite_rom_arbiter dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .frame_start (frame_start),
      .req         (req),
      .req_addr    (req_addr),
      .grant       (grant),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err)
   );

   always #5 Clk = ~Clk;

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      logic [31:0] t;
      t = (32'(a) * 32'h9E37_79B1) ^ (32'(a) << 7) ^ 32'h00A5_5A00;
      return t[DW-1:0];
   endfunction

   // Behavioural ROM: registered read, one cycle latency.
   always @(posedge Clk) rom_data <= rom_word(rom_addr);

   function automatic int model_winner(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // Drive one cycle, advance the reference model, and prepare expectations for the next cycle.
   task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic fs);
      int            w;
      logic [AW-1:0] ad;
      exp_t          e;
      req = r;
      req_addr = a;
      frame_start = fs;
      #1;
      got_grant = grant;
      w = (Reset_n === 1'b1) ? model_winner(r, m_ptr) : -1;
      exp_grant = '0;
      if (w >= 0) begin
         exp_grant[w] = 1'b1;
         ad = a[w*AW +: AW];
         e.due  = cyc + 3;
         e.id   = w;
         e.err  = (ad >= DEPTH);
         e.data = e.err ? 24'hFFFFFF : rom_word(ad);
         exp_q.push_back(e);
         m_ptr = (w + 1) % N;
      end
      if (fs) m_ptr = 0;
      @(posedge Clk);
      #1;
      cyc++;
      exp_v = 1'b0; exp_id = 0; exp_data = '0; exp_err = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         exp_v = 1'b1; exp_id = e.id; exp_data = e.data; exp_err = e.err;
      end
   endtask

   task automatic test_reset;
      req = 4'b1111;
      repeat (2) @(posedge Clk);
      #1;
      n_tests++;
      if (grant !== 4'b0000 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_outputs grant=%b rsp_valid=%b required grant=0000 rsp_valid=0", grant, rsp_valid);
      end
      n_tests++;
      if (rom_addr !== '0 || rsp_id !== 2'd0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_regs rom_addr=%0d id=%0d data=%h err=%b required all zero", rom_addr, rsp_id, rsp_data, rsp_err);
      end
      Reset_n = 1'b1;
      m_ptr = 0;
      #1;
      n_tests++;
      if (grant !== 4'b0001) begin
         n_fail++; $display("FAIL reset_release_grant got=%b required=0001", grant);
      end
   endtask

   task automatic test_rotation;
      logic [N*AW-1:0] a;
      a = {19'd1023, 19'd513, 19'd200, 19'd10};
      for (int k = 0; k < 11; k++) begin
         step((k < 8) ? 4'b1111 : 4'b0000, a, 1'b0);
         if (k < 8) begin
            n_tests++;
            if (got_grant !== (4'b0001 << (k % 4)) || got_grant !== exp_grant) begin
               n_fail++; $display("FAIL rotation_grant k=%0d got=%b required=%b", k, got_grant, exp_grant);
            end
         end
         n_tests++;
         if (rsp_valid !== exp_v || (exp_v && (rsp_id !== 2'(exp_id) || rsp_data !== exp_data || rsp_err !== exp_err))) begin
            n_fail++; $display("FAIL rotation_rsp cyc=%0d got v=%b id=%0d d=%h e=%b required v=%b id=%0d d=%h e=%b",
                               cyc, rsp_valid, rsp_id, rsp_data, rsp_err, exp_v, exp_id, exp_data, exp_err);
         end
      end
   endtask

   task automatic test_skip;
      logic [N*AW-1:0] a;
      logic [N-1:0]    want [3];
      logic [N-1:0]    rq [3];
      a = {19'd77, 19'd300, 19'd45, 19'd10};
      rq[0] = 4'b0001; rq[1] = 4'b1001; rq[2] = 4'b1001;
      want[0] = 4'b0001; want[1] = 4'b1000; want[2] = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         step((k < 3) ? rq[k] : 4'b0000, a, 1'b0);
         if (k < 3) begin
            n_tests++;
            if (got_grant !== want[k] || got_grant !== exp_grant) begin
               n_fail++; $display("FAIL skip_grant k=%0d got=%b required=%b", k, got_grant, want[k]);
            end
         end
         n_tests++;
         if (rsp_valid !== exp_v || (exp_v && (rsp_id !== 2'(exp_id) || rsp_data !== exp_data || rsp_err !== exp_err))) begin
            n_fail++; $display("FAIL skip_rsp cyc=%0d got v=%b id=%0d d=%h required v=%b id=%0d d=%h",
                               cyc, rsp_valid, rsp_id, rsp_data, exp_v, exp_id, exp_data);
         end
      end
   endtask

   task automatic test_out_of_range;
      logic [N*AW-1:0] a;
      int              seen;
      a = {19'd5, 19'd1024, 19'd6, 19'd7};
      seen = 0;
      step(4'b0100, a, 1'b0);
      n_tests++;
      if (got_grant !== 4'b0100 || rom_addr !== '0) begin
         n_fail++; $display("FAIL oor_addr grant=%b rom_addr=%0d required grant=0100 rom_addr=0", got_grant, rom_addr);
      end
      for (int k = 0; k < 3; k++) begin
         step(4'b0000, a, 1'b0);
         if (rsp_valid === 1'b1) begin
            seen++;
            n_tests++;
            if (rsp_err !== 1'b1 || rsp_data !== 24'hFFFFFF || rsp_id !== 2'd2) begin
               n_fail++; $display("FAIL oor_rsp id=%0d d=%h e=%b required id=2 d=ffffff e=1", rsp_id, rsp_data, rsp_err);
            end
         end
         n_tests++;
         if (rsp_valid !== exp_v) begin
            n_fail++; $display("FAIL oor_timing cyc=%0d got v=%b required v=%b", cyc, rsp_valid, exp_v);
         end
      end
      n_tests++;
      if (seen != 1) begin
         n_fail++; $display("FAIL oor_count got=%0d required=1", seen);
      end
   endtask

   task automatic test_frame_start;
      logic [N*AW-1:0] a;
      a = {19'd900, 19'd800, 19'd700, 19'd600};
      step(4'b0100, a, 1'b1);
      n_tests++;
      if (got_grant !== 4'b0100) begin
         n_fail++; $display("FAIL fs_same_cycle_grant got=%b required=0100", got_grant);
      end
      step(4'b1001, a, 1'b0);
      n_tests++;
      if (got_grant !== 4'b0001) begin
         n_fail++; $display("FAIL fs_next_winner got=%b required=0001", got_grant);
      end
      for (int k = 0; k < 3; k++) begin
         step(4'b0000, a, 1'b0);
         n_tests++;
         if (rsp_valid !== exp_v || (exp_v && (rsp_id !== 2'(exp_id) || rsp_data !== exp_data || rsp_err !== exp_err))) begin
            n_fail++; $display("FAIL fs_rsp cyc=%0d got v=%b id=%0d d=%h required v=%b id=%0d d=%h",
                               cyc, rsp_valid, rsp_id, rsp_data, exp_v, exp_id, exp_data);
         end
      end
   endtask

   task automatic test_reset_midstream;
      logic [N*AW-1:0] a;
      int              seen;
      a = {19'd11, 19'd22, 19'd33, 19'd44};
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         step(4'b1111, a, 1'b0);
         n_tests++;
         if (got_grant !== exp_grant || got_grant === 4'b0000) begin
            n_fail++; $display("FAIL mid_accept k=%0d got=%b required=%b", k, got_grant, exp_grant);
         end
      end
      Reset_n = 1'b0;
      exp_q.delete();
      m_ptr = 0;
      #1;
      n_tests++;
      if (rsp_valid !== 1'b0 || grant !== 4'b0000) begin
         n_fail++; $display("FAIL mid_reset_async rsp_valid=%b grant=%b required 0 and 0000", rsp_valid, grant);
      end
      for (int k = 0; k < 6; k++) begin
         if (k == 2) Reset_n = 1'b1;
         step((k < 2) ? 4'b1111 : 4'b0000, a, 1'b0);
         if (rsp_valid === 1'b1) seen++;
         n_tests++;
         if (got_grant !== exp_grant) begin
            n_fail++; $display("FAIL mid_grant k=%0d got=%b required=%b", k, got_grant, exp_grant);
         end
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++; $display("FAIL mid_dropped responses=%0d required=0", seen);
      end
   endtask

   task automatic test_random;
      logic [N*AW-1:0] a;
      logic [N-1:0]    r;
      logic            fs;
      for (int k = 0; k < 303; k++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) a[i*AW +: AW] = AW'($urandom_range(DEPTH, (1 << AW) - 1));
            else a[i*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
         end
         r  = (k < 300) ? N'($urandom_range(0, 15)) : 4'b0000;
         fs = ($urandom_range(0, 15) == 0);
         step(r, a, fs);
         n_tests++;
         if (got_grant !== exp_grant) begin
            n_fail++; $display("FAIL rand_grant cyc=%0d req=%b got=%b required=%b", cyc, r, got_grant, exp_grant);
         end
         n_tests++;
         if (rsp_valid !== exp_v || (exp_v && (rsp_id !== 2'(exp_id) || rsp_data !== exp_data || rsp_err !== exp_err))) begin
            n_fail++; $display("FAIL rand_rsp cyc=%0d got v=%b id=%0d d=%h e=%b required v=%b id=%0d d=%h e=%b",
                               cyc, rsp_valid, rsp_id, rsp_data, rsp_err, exp_v, exp_id, exp_data, exp_err);
         end
         n_tests++;
         if (rom_addr >= DEPTH) begin
            n_fail++; $display("FAIL rand_rom_range rom_addr=%0d required below %0d", rom_addr, DEPTH);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_skip();
      test_out_of_range();
      test_frame_start();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
